mod_reg_deser_buf: RTL

- Parametrised serial-to-parallel word assembler. Collects N beats of W bits each into one N*W-bit word.
- Replaces the single-shot 1-to-4 byte register in the AES datapath, e.g. byte stream to 32-bit column or 128-bit state.
- Adds valid/ready handshakes on both sides, selectable lane order, a synchronous partial-word clear, and a 2-entry output buffer so input can continue while the consumer stalls.

---
 rtl/mod_reg_deser_buf_if.sv | 30 +++
 rtl/mod_reg_deser_buf.sv | 99 +++++++++
 2 files changed

// File: rtl/mod_reg_deser_buf_if.sv
// Bus bundle for the serial-to-parallel word assembler: input beat handshake,
// output word handshake, partial-word clear and occupancy status.
interface mod_reg_deser_buf_if #(
  parameter int unsigned W = 8,
  parameter int unsigned N = 4
);
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  logic              clr;
  logic [W-1:0]      in_data;
  logic              in_valid;
  logic              in_ready;
  logic [N*W-1:0]    out_data;
  logic              out_valid;
  logic              out_ready;
  logic [CW-1:0]     fill_cnt;
  logic [1:0]        full_cnt;

  // Producer/consumer side: drives beats, clear and output acceptance.
  modport master (
    output clr, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, fill_cnt, full_cnt
  );

  // Assembler side.
  modport slave (
    input  clr, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, fill_cnt, full_cnt
  );
endinterface

// File: rtl/mod_reg_deser_buf.sv
// Serial-to-parallel word assembler: collects N beats of W bits into one
// N*W-bit word and queues completed words in a 2-entry output FIFO.
module mod_reg_deser_buf #(
  parameter int unsigned W     = 8,
  parameter int unsigned N     = 4,
  parameter int unsigned ORDER = 0
) (
  input logic               clk,
  input logic               resetn,
  mod_reg_deser_buf_if.slave bus
);
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LastBeat = CW'(N - 1);

  logic [N*W-1:0] acc_q, acc_d;
  logic [CW-1:0]  fill_q, fill_d;
  logic [N*W-1:0] head_q, head_d;
  logic [N*W-1:0] tail_q, tail_d;
  logic [1:0]     full_q, full_d;

  logic           ready;
  logic           accept;
  logic           push;
  logic           pop;
  logic [CW-1:0]  lane;
  logic [N*W-1:0] word;

  // Handshake decode and next state for the accumulator and output FIFO.
  always_comb begin
    ready  = !bus.clr && !(fill_q == LastBeat && full_q == 2'd2);
    accept = bus.in_valid && ready;
    push   = accept && (fill_q == LastBeat);
    pop    = (full_q != 2'd0) && bus.out_ready;

    lane = (ORDER == 1) ? (LastBeat - fill_q) : fill_q;
    word = acc_q;
    word[lane*W +: W] = bus.in_data;

    acc_d  = acc_q;
    fill_d = fill_q;
    head_d = head_q;
    tail_d = tail_q;
    full_d = full_q;

    if (bus.clr) begin
      acc_d  = '0;
      fill_d = '0;
    end else if (accept) begin
      // A completed word leaves the accumulator, so restart from zeroed lanes.
      acc_d  = push ? '0 : word;
      fill_d = push ? '0 : fill_q + 1'b1;
    end

    if (push && pop) begin
      // Occupancy unchanged; with two words the tail advances and the new word
      // takes its place, with one word the new word directly becomes the head.
      if (full_q == 2'd2) begin
        head_d = tail_q;
        tail_d = word;
      end else begin
        head_d = word;
      end
    end else if (push) begin
      if (full_q == 2'd0) head_d = word;
      else                tail_d = word;
      full_d = full_q + 2'd1;
    end else if (pop) begin
      // Popping the last word leaves head_q as-is so out_data holds its value.
      if (full_q == 2'd2) head_d = tail_q;
      full_d = full_q - 2'd1;
    end
  end

  // State registers; reset discards partial and buffered words immediately.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_q  <= '0;
      fill_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      full_q <= '0;
    end else begin
      acc_q  <= acc_d;
      fill_q <= fill_d;
      head_q <= head_d;
      tail_q <= tail_d;
      full_q <= full_d;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_data  = head_q;
  assign bus.out_valid = (full_q != 2'd0);
  assign bus.fill_cnt  = fill_q;
  assign bus.full_cnt  = full_q;

  a_full_bound: assert property (@(posedge clk) disable iff (!resetn) full_q <= 2'd2);
  a_fill_bound: assert property (@(posedge clk) disable iff (!resetn) fill_q <= LastBeat);
endmodule
